// File: rtl/sequence_lock_pkg.sv
// Shared types and display glyphs for the digit-sequence lock.
// Optional code reprogramming is enabled by defining SEQUENCE_LOCK_PROGRAM_EN.
package sequence_lock_pkg;

   typedef enum logic [1:0] {
      ST_ENTRY = 2'd0,
      ST_OPEN  = 2'd1,
      ST_FAIL  = 2'd2,
      ST_PROG  = 2'd3
   } state_t;

   // Segment vector is {A,B,C,D,E,F,G}: A in the MSB, active-high.
   localparam int SEG_A = 6;
   localparam int SEG_B = 5;
   localparam int SEG_C = 4;
   localparam int SEG_D = 3;
   localparam int SEG_E = 2;
   localparam int SEG_F = 1;
   localparam int SEG_G = 0;

   localparam logic [6:0] GLYPH_U     = 7'b0111110;
   localparam logic [6:0] GLYPH_U_LOW = 7'b0011100;
   localparam logic [6:0] GLYPH_F     = 7'b1000111;
   localparam logic [6:0] GLYPH_P     = 7'b1100111;
   localparam logic [6:0] GLYPH_DASH  = 7'b0000001;
   localparam logic [6:0] GLYPH_ZERO  = 7'b1111110;

   localparam int MAX_DEC_DIGIT = 9;

endpackage

// File: rtl/sequence_lock_seg7_decoder.sv
// Combinational decimal digit to seven-segment decoder; anything above 9 shows a dash.
module seg7_decoder
   import sequence_lock_pkg::*;
#(
   parameter int DIGIT_W = 4
) (
   input  logic [DIGIT_W-1:0] digit,
   output logic [6:0]         seg
);

   always_comb begin
      seg = GLYPH_DASH;
      case (digit)
         DIGIT_W'(0): seg = GLYPH_ZERO;
         DIGIT_W'(1): seg = 7'b0110000;
         DIGIT_W'(2): seg = 7'b1101101;
         DIGIT_W'(3): seg = 7'b1111001;
         DIGIT_W'(4): seg = 7'b0110011;
         DIGIT_W'(5): seg = 7'b1011011;
         DIGIT_W'(6): seg = 7'b1011111;
         DIGIT_W'(7): seg = 7'b1110000;
         DIGIT_W'(8): seg = 7'b1111111;
         DIGIT_W'(9): seg = 7'b1111011;
         default:     seg = GLYPH_DASH;
      endcase
   end

endmodule

// File: rtl/sequence_lock.sv
// Configurable digit-sequence lock with error tolerance and registered status display.
// Define SEQUENCE_LOCK_PROGRAM_EN to add the prog port and in-field code reprogramming.
module sequence_lock
   import sequence_lock_pkg::*;
#(
   parameter int                           DIGIT_W      = 4,
   parameter int                           CODE_LEN     = 6,
   parameter int                           MAX_ERRORS   = 2,
   parameter logic [CODE_LEN*DIGIT_W-1:0]  DEFAULT_CODE = 24'h590981,
   localparam int                          ERR_W        = $clog2(MAX_ERRORS+1),
   localparam int                          POS_W        = $clog2(CODE_LEN+1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               digit_valid,
   input  logic [DIGIT_W-1:0] digit,
`ifdef SEQUENCE_LOCK_PROGRAM_EN
   input  logic               prog,
`endif
   output logic               unlocked,
   output logic               locked_out,
   output logic               warn,
   output logic [ERR_W-1:0]   err_count,
   output logic [POS_W-1:0]   pos,
   output logic [6:0]         seg
);

   localparam int CODE_W = CODE_LEN * DIGIT_W;

   state_t             state_q, state_nxt;
   logic [POS_W-1:0]   pos_q, pos_nxt;
   logic [ERR_W-1:0]   err_q, err_nxt;
   logic [6:0]         seg_q, seg_nxt;
   logic [CODE_W-1:0]  code_q;
   logic [DIGIT_W-1:0] exp_digit;
   logic [6:0]         dec_seg;
   logic               digit_ok;
   logic               digit_hit;

`ifdef SEQUENCE_LOCK_PROGRAM_EN
   logic [CODE_W-1:0]  code_nxt;
`else
   assign code_q = DEFAULT_CODE;
`endif

   seg7_decoder #(.DIGIT_W(DIGIT_W)) u_dec (
      .digit (digit),
      .seg   (dec_seg)
   );

   // Field pos of the code, first digit in the most significant field.
   always_comb begin
      exp_digit = '0;
      for (int i = 0; i < CODE_LEN; i++) begin
         if (pos_q == POS_W'(i))
            exp_digit = code_q[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
      end
   end

   assign digit_ok  = (digit <= DIGIT_W'(MAX_DEC_DIGIT));
   assign digit_hit = digit_ok && (digit == exp_digit);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_ENTRY;
         pos_q   <= '0;
         err_q   <= '0;
         seg_q   <= GLYPH_ZERO;
`ifdef SEQUENCE_LOCK_PROGRAM_EN
         code_q  <= DEFAULT_CODE;
`endif
      end else begin
         state_q <= state_nxt;
         pos_q   <= pos_nxt;
         err_q   <= err_nxt;
         seg_q   <= seg_nxt;
`ifdef SEQUENCE_LOCK_PROGRAM_EN
         code_q  <= code_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt = state_q;
      pos_nxt   = pos_q;
      err_nxt   = err_q;
      seg_nxt   = seg_q;
`ifdef SEQUENCE_LOCK_PROGRAM_EN
      code_nxt  = code_q;
`endif
      case (state_q)
         ST_ENTRY: begin
            if (digit_valid) begin
               seg_nxt = dec_seg;
               if (digit_hit) begin
                  if (pos_q == POS_W'(CODE_LEN-1)) begin
                     state_nxt = ST_OPEN;
                     pos_nxt   = POS_W'(CODE_LEN);
                     seg_nxt   = (err_q == '0) ? GLYPH_U : GLYPH_U_LOW;
                  end else begin
                     pos_nxt = pos_q + POS_W'(1);
                  end
               end else begin
                  // Wrong digit: stay on the same position so the user can retry it.
                  err_nxt = err_q + ERR_W'(1);
                  if (err_nxt == ERR_W'(MAX_ERRORS)) begin
                     state_nxt = ST_FAIL;
                     seg_nxt   = GLYPH_F;
                  end
               end
            end
         end
         ST_OPEN: begin
`ifdef SEQUENCE_LOCK_PROGRAM_EN
            if (prog) begin
               state_nxt = ST_PROG;
               pos_nxt   = '0;
               seg_nxt   = GLYPH_P;
            end
`endif
         end
         ST_FAIL: begin
         end
`ifdef SEQUENCE_LOCK_PROGRAM_EN
         ST_PROG: begin
            if (digit_valid && digit_ok) begin
               for (int i = 0; i < CODE_LEN; i++) begin
                  if (pos_q == POS_W'(i))
                     code_nxt[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W] = digit;
               end
               if (pos_q == POS_W'(CODE_LEN-1)) begin
                  state_nxt = ST_ENTRY;
                  pos_nxt   = '0;
                  err_nxt   = '0;
                  seg_nxt   = dec_seg;
               end else begin
                  pos_nxt = pos_q + POS_W'(1);
               end
            end
         end
`endif
         default: begin
            state_nxt = ST_ENTRY;
            pos_nxt   = '0;
            err_nxt   = '0;
            seg_nxt   = GLYPH_ZERO;
         end
      endcase
   end

   always_comb begin
      unlocked   = (state_q == ST_OPEN);
      locked_out = (state_q == ST_FAIL);
      warn       = (err_q != '0);
      err_count  = err_q;
      pos        = pos_q;
      seg        = seg_q;
   end

endmodule

// File: tb/tb_sequence_lock.sv
// Self-checking bench for sequence_lock: directed test-plan steps, then random entries against a digit-list model.
module tb_sequence_lock;

   localparam int CL = 6;
   localparam int ME = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic       digit_valid;
   logic [3:0] digit;
`ifdef SEQUENCE_LOCK_PROGRAM_EN
   logic       prog;
`endif
   logic       unlocked;
   logic       locked_out;
   logic       warn;
   logic [1:0] err_count;
   logic [2:0] pos;
   logic [6:0] seg;

   always #5 clk = ~clk;

   sequence_lock #(
      .DIGIT_W      (4),
      .CODE_LEN     (CL),
      .MAX_ERRORS   (ME),
      .DEFAULT_CODE (24'h590981)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .digit_valid (digit_valid),
      .digit       (digit),
`ifdef SEQUENCE_LOCK_PROGRAM_EN
      .prog        (prog),
`endif
      .unlocked    (unlocked),
      .locked_out  (locked_out),
      .warn        (warn),
      .err_count   (err_count),
      .pos         (pos),
      .seg         (seg)
   );

   int total = 0;
   int bad   = 0;

   // Model: mode 0=entering, 1=open, 2=failed, 3=programming.
   int         m_mode;
   int         m_pos;
   int         m_err;
   logic [6:0] m_seg;
   int         m_code [CL];

   localparam logic [6:0] DIGS [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                        7'b1111111, 7'b1111011};

   function automatic logic [6:0] show(int d);
      if (d >= 0 && d <= 9) return DIGS[d];
      return 7'b0000001;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_pos = 0; m_err = 0; m_seg = 7'b1111110;
      m_code = '{5, 9, 0, 9, 8, 1};
   endtask

   task automatic model_entry(int d);
      if (m_mode == 0) begin
         if (d <= 9 && d == m_code[m_pos]) begin
            if (m_pos == CL - 1) begin
               m_mode = 1; m_pos = CL;
               m_seg = (m_err == 0) ? 7'b0111110 : 7'b0011100;
            end else begin
               m_pos++; m_seg = show(d);
            end
         end else begin
            m_err++;
            if (m_err == ME) begin m_mode = 2; m_seg = 7'b1000111; end
            else m_seg = show(d);
         end
      end else if (m_mode == 3) begin
         if (d <= 9) begin
            m_code[m_pos] = d;
            if (m_pos == CL - 1) begin
               m_mode = 0; m_pos = 0; m_err = 0; m_seg = show(d);
            end else m_pos++;
         end
      end
   endtask

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(string tag);
      check({tag, ".unlocked"},   32'(unlocked),   32'(m_mode == 1));
      check({tag, ".locked_out"}, 32'(locked_out), 32'(m_mode == 2));
      check({tag, ".warn"},       32'(warn),       32'(m_err > 0));
      check({tag, ".err_count"},  32'(err_count),  32'(m_err));
      check({tag, ".pos"},        32'(pos),        32'(m_pos));
      check({tag, ".seg"},        32'(seg),        32'(m_seg));
   endtask

   task automatic step(bit v, int d, string tag);
      @(negedge clk);
      digit_valid = v;
      digit       = d[3:0];
      @(posedge clk);
      #1;
      if (v) model_entry(d);
      digit_valid = 1'b0;
      check_all(tag);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      digit_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      check_all("reset");
   endtask

   initial begin
      int seq_a [6];
      int seq_b [7];
      int d;
      bit v;
      reset = 1'b1;
      digit_valid = 1'b0;
      digit = 4'd0;
`ifdef SEQUENCE_LOCK_PROGRAM_EN
      prog = 1'b0;
`endif
      model_reset();
      do_reset();

      // Clean entry of the default code
      seq_a = '{5, 9, 0, 9, 8, 1};
      foreach (seq_a[i]) step(1'b1, seq_a[i], "clean");
      check("clean.open_glyph", 32'(seg), 32'(7'b0111110));
      check("clean.unlocked", 32'(unlocked), 32'd1);
      step(1'b1, 5, "open_ignores");

      // One tolerated mistake
      do_reset();
      step(1'b1, 5, "warn");
      step(1'b1, 7, "warn");
      check("warn.flag", 32'(warn), 32'd1);
      check("warn.pos", 32'(pos), 32'd1);
      seq_b = '{9, 0, 9, 8, 1, 0, 0};
      for (int i = 0; i < 5; i++) step(1'b1, seq_b[i], "warn");
      check("warn.open_glyph", 32'(seg), 32'(7'b0011100));

      // Lockout then sticky
      do_reset();
      step(1'b1, 5, "lock");
      step(1'b1, 3, "lock");
      step(1'b1, 4, "lock");
      check("lock.locked_out", 32'(locked_out), 32'd1);
      step(1'b1, 9, "lock_sticky");
      step(1'b1, 5, "lock_sticky");
      check("lock.glyph", 32'(seg), 32'(7'b1000111));

      // Out-of-range digit
      do_reset();
      step(1'b1, 12, "dash");
      check("dash.glyph", 32'(seg), 32'(7'b0000001));
      check("dash.err", 32'(err_count), 32'd1);

      // Reset dominates a strobe mid-sequence
      do_reset();
      step(1'b1, 5, "midreset");
      step(1'b1, 9, "midreset");
      step(1'b1, 0, "midreset");
      @(negedge clk);
      reset = 1'b1; digit_valid = 1'b1; digit = 4'd9;
      @(posedge clk);
      #1;
      reset = 1'b0; digit_valid = 1'b0;
      model_reset();
      check_all("midreset.after");

      // Random entries, biased towards the correct next digit
      for (int r = 0; r < 40; r++) begin
         do_reset();
         for (int k = 0; k < 14; k++) begin
            if (m_mode == 0 && m_pos < CL && $urandom_range(0, 9) < 7) d = m_code[m_pos];
            else d = int'($urandom_range(0, 15));
            v = ($urandom_range(0, 4) != 0);
            step(v, d, "random");
         end
      end

`ifdef SEQUENCE_LOCK_PROGRAM_EN
      // Reprogram the code to 1..6 from the open state
      do_reset();
      foreach (seq_a[i]) step(1'b1, seq_a[i], "prog_open");
      @(negedge clk);
      prog = 1'b1; digit_valid = 1'b1; digit = 4'd3;
      @(posedge clk);
      #1;
      prog = 1'b0; digit_valid = 1'b0;
      if (m_mode == 1) begin m_mode = 3; m_pos = 0; m_seg = 7'b1100111; end
      check_all("prog_enter");
      step(1'b1, 11, "prog_skip");
      for (int i = 1; i <= 6; i++) step(1'b1, i, "prog_write");
      step(1'b1, 5, "prog_olddigit");
      check("prog.err", 32'(err_count), 32'd1);
      for (int i = 1; i <= 6; i++) step(1'b1, i, "prog_newcode");
      check("prog.unlocked", 32'(unlocked), 32'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sequence_lock.md
# sequence_lock

Parametrised digit-sequence lock with configurable code length, digit width and error tolerance, plus a registered seven-segment status display. It sits between the keypad/switch input synchroniser and the board's seven-segment and LED drivers. It generalises the fixed 6-digit, single-warning lock into a configurable block: code held in a register, up to MAX_ERRORS wrong entries tolerated, and optional field reprogramming of the code.

## Interface
- DIGIT_W, 4: width of one entered digit.
- CODE_LEN, 6: number of digits in the code (≥1).
- MAX_ERRORS, 2: wrong entries that cause lockout (≥1); MAX_ERRORS-1 are tolerated.
- DEFAULT_CODE, 24'h590981: reset code, CODE_LEN×DIGIT_W bits, first digit in the most significant field.
- clk  in  1  clock, rising edge.
- reset  in  1  reset, synchronous, active-high.
- digit_valid  in  1  one-cycle strobe: digit is an entry.
- digit  in  DIGIT_W  entered digit value.
- prog  in  1  enter programming mode (only with SEQUENCE_LOCK_PROGRAM_EN).
- unlocked  out  1  code accepted (OPEN state).
- locked_out  out  1  error limit reached (FAIL state).
- warn  out  1  err_count > 0.
- err_count  out  $clog2(MAX_ERRORS+1)  wrong entries so far.
- pos  out  $clog2(CODE_LEN+1)  index of the next expected digit.
- seg  out  7  segments {A,B,C,D,E,F,G}, seg[6]=A, active-high.

## Operation
- States: ENTRY, OPEN, FAIL, PROG (PROG exists only with the macro).
- Reset values: state ENTRY, pos 0, err_count 0, unlocked 0, locked_out 0, warn 0, seg = glyph '0' (7'b1111110), code register = DEFAULT_CODE.
- ENTRY, digit_valid=1, digit equals code field[pos]:
  - pos<CODE_LEN-1: increment pos.
  - pos=CODE_LEN-1: go to OPEN, pos=CODE_LEN.
- ENTRY, digit_valid=1, digit differs: pos holds, so the user retries the same position. err_count increments; if the new value equals MAX_ERRORS, go to FAIL.
- Digit values >9 are always wrong.
- OPEN and FAIL are sticky until reset. digit_valid is ignored in both. err_count is frozen.
- Display:
  - ENTRY: last entry's digit, decoded 0–9; any value >9 shows '-' (7'b0000001).
  - OPEN: 'U' (7'b0111110) if err_count=0, 'u' (7'b0011100) otherwise.
  - FAIL: 'F' (7'b1000111).

## Timing
- All outputs are registered. An entry sampled at edge N is reflected on every output after edge N.
- Back-to-back strobes are legal; each cycle is one entry.
- reset dominates digit_valid and prog in the same cycle.
- Reset mid-sequence: pos and err_count clear; the code register reloads DEFAULT_CODE.
- Only the final-digit correct entry asserts unlocked. The error that brings err_count to MAX_ERRORS asserts locked_out on the same edge.
- With MAX_ERRORS=1, the first wrong digit goes straight to FAIL and warn never asserts in ENTRY.

## Configuration
- SEQUENCE_LOCK_PROGRAM_EN defined:
  - Port prog and state PROG exist.
  - In OPEN, prog=1 moves to PROG with pos 0, seg 'P' (7'b1100111).
  - In PROG, each digit_valid with digit ≤9 writes code field[pos] and increments pos. Values >9 are ignored.
  - After the CODE_LEN-th write, go to ENTRY with pos 0 and err_count 0.
  - prog is ignored outside OPEN.
- Undefined: no prog port, no PROG state, and the code register is the constant DEFAULT_CODE.

## Structure
- Package sequence_lock_pkg:
  - state enum.
  - Glyph constants: GLYPH_U, GLYPH_U_LOW, GLYPH_F, GLYPH_P, GLYPH_DASH, GLYPH_ZERO.
  - Segment bit ordering.
- Sub-module seg7_decoder: combinational DIGIT_W→7 decoder, 0–9, else dash. It is instantiated once; its output is muxed with the glyphs and registered.

## Test plan
- Code 5,9,0,9,8,1 entered cleanly → unlocked=1 after the 6th edge, seg=7'b0111110, err_count=0.
- 5, 7, 9,0,9,8,1 (MAX_ERRORS=2) → after the 7: warn=1, pos=1. Final result: unlocked=1, seg=7'b0011100.
- 5, 3, 4 → locked_out=1 after the 4; further entries leave the state unchanged; seg=7'b1000111.
- Digit 4'hC in ENTRY → seg=7'b0000001, err_count+1.
- reset asserted together with digit_valid at pos=3 → next cycle: pos=0, err_count=0, seg=7'b1111110.
- With macro: unlock, then prog, then program 1,2,3,4,5,6; after that, 1–6 unlocks and 5,9,… counts an error.
